// File: rtl/ttl_74165.sv
// ttl_74165: parallel-in / serial-out shift register in the style of the
// 74LS165, fully synchronous to Clk. Parallel words load on a rising edge,
// shift out MSB-first on QH, and can be cascaded through SER.
//
// Optional feature: define TTL_74165_QHN_EN to add the complementary serial
// output QHn (= ~QH, reset value 1). With the macro undefined the port does
// not exist and behaviour is otherwise identical.
//
// Legal WIDTH range is 2..16. DELAY_RISE / DELAY_FALL are simulation-only
// output delays in ns; synthesis ignores them.

`timescale 1ns/1ps

module ttl_74165 #(
  parameter int WIDTH      = 8,
  parameter int DELAY_RISE = 20,
  parameter int DELAY_FALL = 21
) (
  input  logic             Clk,
  input  logic             RESETn,
  input  logic             LOADn,
  input  logic             CLK_INH,
  input  logic             SER,
  input  logic [WIDTH-1:0] D,
  output logic             QH,
  output logic [WIDTH-1:0] Q
`ifdef TTL_74165_QHN_EN
  ,
  output logic             QHn
`endif
);

  // Width of the bundle of outputs that pass through the delay stage:
  // the register itself, plus the complementary serial bit when enabled.
`ifdef TTL_74165_QHN_EN
  localparam int OW = WIDTH + 1;
`else
  localparam int OW = WIDTH;
`endif

  logic [WIDTH-1:0] shift_reg;

  // Register update: async clear, then load over inhibit over shift.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; with blocking assignments
  // the shift would ripple through the whole register in one edge.
  always_ff @(posedge Clk or negedge RESETn) begin
    if (!RESETn) begin
      shift_reg <= '0;
    end else if (!LOADn) begin
      // Load dominates the clock inhibit, as on the LS165; SER is ignored.
      shift_reg <= D;
    end else if (!CLK_INH) begin
      // MSB leaves on QH, SER enters at bit 0; the old MSB is discarded.
      shift_reg <= {shift_reg[WIDTH-2:0], SER};
    end
  end

  // Undelayed view of everything that leaves the block.
  logic [OW-1:0] out_now;
  logic [OW-1:0] out_rise;
  logic [OW-1:0] out_fall;
  logic [OW-1:0] out_dly;

`ifdef TTL_74165_QHN_EN
  assign out_now = {~shift_reg[WIDTH-1], shift_reg};
`else
  assign out_now = shift_reg;
`endif

  // Separate rise/fall delays are built from two single-delay copies of the
  // same signal. When the rise delay is the shorter one, OR-ing the copies
  // makes a 0->1 edge follow the early copy and a 1->0 edge follow the late
  // copy; when the fall delay is shorter, AND-ing gives the mirror image.
  // Each bit therefore rises after DELAY_RISE and falls after DELAY_FALL.
  assign #(DELAY_RISE) out_rise = out_now;
  assign #(DELAY_FALL) out_fall = out_now;

  generate
    if (DELAY_RISE <= DELAY_FALL) begin : g_rise_first
      assign out_dly = out_rise | out_fall;
    end else begin : g_fall_first
      assign out_dly = out_rise & out_fall;
    end
  endgenerate

  // QH is taken straight from the register MSB: no extra pipeline stage.
  assign Q  = out_dly[WIDTH-1:0];
  assign QH = out_dly[WIDTH-1];

`ifdef TTL_74165_QHN_EN
  assign QHn = out_dly[WIDTH];
`endif

endmodule

// File: tb/tb_ttl_74165.sv
// tb_ttl_74165: scoreboard bench for ttl_74165. Each stimulus step drives the
// inputs for one rising edge and queues the hand-computed register value for
// that edge; an independent monitor pops and compares on every falling edge,
// well after the output delays have settled.

`timescale 1ns/1ps

module tb_ttl_74165;

  localparam int WIDTH = 8;

  logic             Clk = 1'b0;
  logic             RESETn;
  logic             LOADn;
  logic             CLK_INH;
  logic             SER;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] D_up;
  logic             casc;

  logic             QH;
  logic [WIDTH-1:0] Q;
  logic             up_qh;
  logic [WIDTH-1:0] up_q;
  logic             dn_ser;
`ifdef TTL_74165_QHN_EN
  logic             QHn;
  logic             up_qhn;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  // Downstream serial input: bench SER normally, upstream QH when cascaded.
  assign dn_ser = casc ? up_qh : SER;

  always #50 Clk = ~Clk;

  ttl_74165 #(.WIDTH(WIDTH), .DELAY_RISE(20), .DELAY_FALL(21)) u_dut (
    .Clk     (Clk),
    .RESETn  (RESETn),
    .LOADn   (LOADn),
    .CLK_INH (CLK_INH),
    .SER     (dn_ser),
    .D       (D),
    .QH      (QH),
    .Q       (Q)
`ifdef TTL_74165_QHN_EN
    ,
    .QHn     (QHn)
`endif
  );

  ttl_74165 #(.WIDTH(WIDTH), .DELAY_RISE(20), .DELAY_FALL(21)) u_up (
    .Clk     (Clk),
    .RESETn  (RESETn),
    .LOADn   (LOADn),
    .CLK_INH (CLK_INH),
    .SER     (1'b0),
    .D       (D_up),
    .QH      (up_qh),
    .Q       (up_q)
`ifdef TTL_74165_QHN_EN
    ,
    .QHn     (up_qhn)
`endif
  );

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one edge's inputs shortly after a falling edge and queue the
  // register value expected once the following rising edge has happened.
  task automatic step(input logic rst, input logic ld, input logic inh,
                      input logic ser, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] eq);
    @(negedge Clk);
    #5;
    RESETn  = rst;
    LOADn   = ld;
    CLK_INH = inh;
    SER     = ser;
    D       = d;
    exp_q.push_back(eq);
  endtask

  // Monitor: on each falling edge compare the outputs against the oldest
  // queued expectation.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q",  16'(Q),  16'(e));
        check("qh", 16'(QH), 16'(e[WIDTH-1]));
`ifdef TTL_74165_QHN_EN
        check("qhn", 16'(QHn), 16'(~e[WIDTH-1]));
`endif
      end
    end
  end

  // Directed vectors.
  initial begin
    logic [WIDTH-1:0] cas_tab [16];
    logic [WIDTH-1:0] fill_tab [8];
    logic [WIDTH-1:0] a5_tab [8];

    cas_tab  = '{8'h12, 8'h24, 8'h48, 8'h91, 8'h23, 8'h46, 8'h8D, 8'h1A,
                 8'h34, 8'h68, 8'hD0, 8'hA0, 8'h40, 8'h80, 8'h00, 8'h00};
    fill_tab = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    a5_tab   = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};

    RESETn  = 1'b1;
    LOADn   = 1'b0;
    CLK_INH = 1'b0;
    SER     = 1'b0;
    D       = 8'hA5;
    D_up    = 8'h00;
    casc    = 1'b0;
    #1 RESETn = 1'b0;

    // Reset: outputs clear without any clock edge.
    #39;
    check("rst_q_async",  16'(Q),  16'h0000);
    check("rst_qh_async", 16'(QH), 16'h0000);
`ifdef TTL_74165_QHN_EN
    check("rst_qhn_async", 16'(QHn), 16'h0001);
`endif

    // Reset held with a pending load: every edge is ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00);

    // Load A5, then 8 shifts with SER=0.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, a5_tab[i]);

    // Inhibit: load C3, freeze 5 edges, then one shift.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hC3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'hC3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h86);

    // Load dominance over inhibit, with SER=1 on the same edge.
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h3C);

    // Serial fill from a cleared register.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, fill_tab[i]);

    // LOADn held low reloads D every edge.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h5A);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h96, 8'h96);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 8'h01);

    // Reset mid-shift: load FF, 3 shifts, then assert reset between edges.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFE);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFC);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hF8);
    @(negedge Clk);
    #5 RESETn = 1'b0;
    #30;
    check("midrst_q",  16'(Q),  16'h0000);
    check("midrst_qh", 16'(QH), 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h01);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02);

    // Cascade: downstream loads 12, upstream 34; 16 edges stream 0x1234.
    @(negedge Clk);
    #1;
    casc = 1'b1;
    D_up = 8'h34;
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h12, cas_tab[0]);
    for (int i = 1; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, cas_tab[i]);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
